// File: rtl/uart_rx_byte_if.sv
// Byte-stream handshake between the UART receiver (master) and its consumer (slave).
// data_valid holds until the consumer takes data_out with data_ready.
interface uart_rx_byte_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises rx, samples mid-bit, checks the stop bit and
// hands complete bytes to a one-deep valid/ready holding buffer.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic           clk_out1,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           rx,
  input  logic           clr_err,
  uart_rx_byte_if.master byte_if,
  output logic           busy,
  output logic           frame_err,
  output logic           overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  logic             rx_p0;
  logic             rx_s_p1;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             stop_ok, stop_bad;
  logic             dlv_p2;
  logic             ovr_set;

  // Stage p0/p1: two-flop synchroniser; only rx_s_p1 is used downstream
  always_ff @(posedge clk_out1 or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0   <= 1'b1;
      rx_s_p1 <= 1'b1;
    end else begin
      rx_p0   <= rx;
      rx_s_p1 <= rx_p0;
    end
  end

  always_ff @(posedge clk_out1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      dlv_p2    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      dlv_p2    <= stop_ok;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    if (!ena && state_q != IDLE) begin
      state_d   = IDLE;
      cnt_d     = '0;
      bit_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ena && !rx_s_p1) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            // A start bit that is high again at mid-bit was only a glitch
            state_d   = rx_s_p1 ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            shreg_d = {rx_s_p1, shreg_q[7:1]};
            if (bit_idx_q == 3'd7) state_d = STOP;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (rx_s_p1) begin
              stop_ok = 1'b1;
              state_d = IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (rx_s_p1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign ovr_set = dlv_p2 && byte_if.data_valid && !byte_if.data_ready;

  // Stage p2: delivery into the holding buffer one cycle after the stop sample
  always_ff @(posedge clk_out1 or negedge rst_n) begin
    if (!rst_n) begin
      byte_if.data_out   <= '0;
      byte_if.data_valid <= 1'b0;
      frame_err          <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      if (dlv_p2) begin
        if (!byte_if.data_valid || byte_if.data_ready) begin
          byte_if.data_out   <= shreg_q;
          byte_if.data_valid <= 1'b1;
        end
      end else if (byte_if.data_valid && byte_if.data_ready) begin
        byte_if.data_valid <= 1'b0;
      end
      if (stop_bad)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial UART receiver (8N1) that is the upstream counterpart of the FSM's uart_tx output.
- Assembles bytes from an external rx line and presents them on a valid/ready byte interface.
- Feeds the CPU-side program/operand path; in loopback it consumes the FSM's uart_tx stream directly.
- Handles synchronisation, mid-bit sampling, framing checks, one-byte holding buffer, and overrun detection.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2, cycles from the detected start edge to the start-bit mid-sample.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- ena  in  1  receiver enable; 0 aborts or blocks reception
- rx  in  1  asynchronous serial input, idle high
- clr_err  in  1  single-cycle pulse that clears the sticky error flags
- data_ready  in  1  consumer accepts data_out this cycle
- data_out  out  8  received byte, LSB received first
- data_valid  out  1  data_out holds an unconsumed byte
- busy  out  1  state != IDLE
- frame_err  out  1  sticky: stop bit sampled 0
- overrun  out  1  sticky: byte completed while the buffer was full and not being drained

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; sync flops=1; counters=0; shift register=0.
  - data_out=0, data_valid=0, busy=0, frame_err=0, overrun=0.
- rx passes through a 2-FF synchroniser (rx_s); all decisions use rx_s only, giving 2 cycles of input latency.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: if ena=1 and rx_s=0, go to START with bit counter=0.
- START: count to HALF_BIT-1, then sample rx_s.
  - rx_s=0: go to DATA, counter=0, bit_idx=0.
  - rx_s=1: glitch, return to IDLE with no error.
- DATA: count to CLKS_PER_BIT-1, then sample.
  - Shift the sample in at the MSB, shifting right (LSB first on the wire).
  - bit_idx increments per sample; after the 8th sample, go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample.
  - rx_s=1: deliver the byte, go to IDLE.
  - rx_s=0: set frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from being read as repeated start bits.
- Delivery, on the cycle after the valid stop sample:
  - data_valid=0: load data_out, set data_valid=1.
  - data_valid=1 and data_ready=1 on the same cycle: load the new byte, data_valid stays 1 (seamless).
  - data_valid=1 and data_ready=0: keep the old byte, drop the new one, set overrun.
- Consumption: data_valid & data_ready with no delivery clears data_valid next edge; data_out is unchanged.
- Latency: data_valid rises on the clock edge following the stop-bit mid-sample. That edge is 2 + HALF_BIT + 9*CLKS_PER_BIT (±1) cycles after the rx falling edge.
- ena=0 in any state other than IDLE: return to IDLE next edge and clear counters. The holding buffer and error flags are retained, and no error is raised.
- clr_err clears frame_err and overrun. If the same cycle sets a flag, the set wins.
- busy is a combinational decode of state != IDLE.
- Counters are sized $clog2(CLKS_PER_BIT); the bit counter has no wrap beyond 7 (STOP transition).

Test Plan (CLKS_PER_BIT=8, HALF_BIT=4):
- Single byte: send 0xA5 8N1, data_ready=0 → data_valid=1, data_out=0xA5, frame_err=0, overrun=0; pulse data_ready → data_valid=0 next edge.
- Back-to-back: send 0x3C then 0xC3 with data_ready=1 held → two single-cycle valid pulses carrying 0x3C then 0xC3, no overrun.
- Overrun: send 0x11 then 0x22 with data_ready=0 → data_out stays 0x11, overrun=1 after the second stop bit; clr_err → overrun=0.
- Framing: send 0x55 with stop bit=0, then hold rx low for 20 cycles → frame_err=1, data_valid=0, state held in WAIT_HIGH until rx high, then the next byte 0x0F is received correctly.
- Glitch/abort:
  - 2-cycle low pulse on idle rx → return to IDLE, no valid, no error.
  - Drop ena mid-DATA → busy=0 next edge, no valid, no error.
- Async reset: assert reset mid-frame off-edge → all outputs 0 immediately; after release, 0x81 is received cleanly.
